// File: rtl/spi_exe_unit_gen.sv
// SPI-attached execution unit: shifts in an operand/opcode frame, executes it, and
// returns {argA, argB, oper, result, flags} during the next selected frame.
module spi_exe_unit_gen #(
    parameter int unsigned N       = 4,
    parameter int unsigned M       = 4,
    parameter int unsigned CS_W    = 3,
    parameter int unsigned CS_ADDR = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            i_clk_p,
    input  logic            i_rst_n,
    input  logic            i_sclk,
    input  logic            i_mosi,
    input  logic [CS_W-1:0] i_cs,
    output logic            o_miso,
    output logic            o_done,
    output logic            o_err
);

    localparam int unsigned F  = 3 * N + M + 4;
    // Only the argA/argB/oper part of the frame is kept; trailing bits are don't-care.
    localparam int unsigned IW = 2 * N + M;
    localparam int unsigned CW = $clog2(F + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StShift, StExec, StLoad} state_e;

    // Synchroniser and edge-detect flops
    logic            sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic            mosi_s1_q, mosi_s2_q;
    logic [CS_W-1:0] cs_s1_q, cs_s2_q;

    logic sclk_rise, sclk_fall, sel;

    // Control state
    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            wait_desel_q, wait_desel_d;
    logic [IW-1:0]   in_sr_q, in_sr_d;
    logic [F-1:0]    out_sr_q, out_sr_d;
    logic            done_q, err_q;
    logic            abort_c, latch_c, load_c;

    // Executed operands and results; together they form the output register image
    logic [N-1:0]    arg_a_q, arg_b_q, result_q;
    logic [M-1:0]    oper_q;
    logic [3:0]      flags_q;

    logic [N-1:0]    alu_res;
    logic            alu_bf;
    logic [3:0]      alu_flags;
    logic [N:0]      sum_w, diff_w;

    // Two-flop synchronisers plus one extra SCLK stage for edge detection
    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            cs_s1_q   <= '0;
            cs_s2_q   <= '0;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
            cs_s1_q   <= i_cs;
            cs_s2_q   <= cs_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign sel       = (cs_s2_q == CS_W'(CS_ADDR));

    // Next-state logic: frame sequencing, abort detection and shift registers
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        wait_desel_d = wait_desel_q;
        in_sr_d      = in_sr_q;
        out_sr_d     = out_sr_q;
        abort_c      = 1'b0;
        latch_c      = 1'b0;
        load_c       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!sel) begin
                    wait_desel_d = 1'b0;
                end else if (!wait_desel_q) begin
                    state_d    = StShift;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    in_sr_d    = '0;
                    out_sr_d   = {arg_a_q, arg_b_q, oper_q, result_q, flags_q};
                end
            end
            StShift: begin
                // Last rise wins over a simultaneous deselect
                if (sclk_rise && (bit_cnt_q == CW'(F - 1))) begin
                    bit_cnt_d = CW'(F);
                    state_d   = StExec;
                end else if (!sel) begin
                    abort_c = 1'b1;
                    in_sr_d = '0;
                    state_d = StIdle;
                end else if (!sclk_rise && !sclk_fall && (idle_cnt_q == TW'(TIMEOUT - 1))) begin
                    abort_c      = 1'b1;
                    in_sr_d      = '0;
                    wait_desel_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    if (sclk_rise) begin
                        if (bit_cnt_q < CW'(IW)) begin
                            in_sr_d = {in_sr_q[IW-2:0], mosi_s2_q};
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (sclk_fall) begin
                        out_sr_d = {out_sr_q[F-2:0], 1'b0};
                    end
                    idle_cnt_d = (sclk_rise || sclk_fall) ? '0 : idle_cnt_q + 1'b1;
                end
            end
            StExec: begin
                latch_c = 1'b1;
                state_d = StLoad;
            end
            StLoad: begin
                load_c       = 1'b1;
                wait_desel_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and shift-register state
    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            wait_desel_q <= 1'b0;
            in_sr_q      <= '0;
            out_sr_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            wait_desel_q <= wait_desel_d;
            in_sr_q      <= in_sr_d;
            out_sr_q     <= out_sr_d;
            done_q       <= load_c;
            err_q        <= abort_c;
        end
    end

    // Operand latch in EXEC, result/flags capture in LOAD
    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            arg_a_q  <= '0;
            arg_b_q  <= '0;
            oper_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (latch_c) begin
                arg_a_q <= in_sr_q[IW-1 -: N];
                arg_b_q <= in_sr_q[IW-1-N -: N];
                oper_q  <= in_sr_q[M-1:0];
            end
            if (load_c) begin
                result_q <= alu_res;
                flags_q  <= alu_flags;
            end
        end
    end

    // ALU: unsigned, modulo 2^N; BF carries carry/borrow/shifted-out bit
    always_comb begin
        alu_res = '0;
        alu_bf  = 1'b0;
        sum_w   = {1'b0, arg_a_q} + {1'b0, arg_b_q};
        diff_w  = {1'b0, arg_a_q} - {1'b0, arg_b_q};
        if ((oper_q >> 3) == '0) begin
            case (oper_q[2:0])
                3'd0: begin
                    alu_res = sum_w[N-1:0];
                    alu_bf  = sum_w[N];
                end
                3'd1: begin
                    alu_res = diff_w[N-1:0];
                    alu_bf  = diff_w[N];
                end
                3'd2: alu_res = arg_a_q & arg_b_q;
                3'd3: alu_res = arg_a_q | arg_b_q;
                3'd4: alu_res = arg_a_q ^ arg_b_q;
                3'd5: alu_res = ~arg_a_q;
                3'd6: begin
                    alu_res = {arg_a_q[N-2:0], 1'b0};
                    alu_bf  = arg_a_q[N-1];
                end
                3'd7: begin
                    alu_res = {1'b0, arg_a_q[N-1:1]};
                    alu_bf  = arg_a_q[0];
                end
                default: alu_res = '0;
            endcase
        end
    end

    assign alu_flags = {~^alu_res, (alu_res == '0), alu_bf, alu_res[N-1]};

    assign o_miso = (state_q == StShift) && sel ? out_sr_q[F-1] : 1'b0;
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_spi_exe_unit_gen.sv
// Scoreboard bench for spi_exe_unit_gen: directed frames from the datasheet examples
// followed by randomized frames checked against an arithmetic reference model.
module tb_spi_exe_unit_gen;

    localparam int N       = 4;
    localparam int M       = 4;
    localparam int CS_W    = 3;
    localparam int SEL     = 3;
    localparam int TIMEOUT = 64;
    localparam int F       = 3 * N + M + 4;

    typedef struct packed {
        logic         is_err;
        logic [F-1:0] miso;
    } exp_t;

    logic            i_clk_p = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_sclk  = 1'b0;
    logic            i_mosi  = 1'b0;
    logic [CS_W-1:0] i_cs    = '0;
    logic            o_miso, o_done, o_err;

    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         sb[$];
    logic [F-1:0] last_cap = '0;
    logic [F-1:0] model_out = '0;
    logic         nsel_bad;

    spi_exe_unit_gen #(
        .N(N), .M(M), .CS_W(CS_W), .CS_ADDR(SEL), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk_p(i_clk_p),
        .i_rst_n(i_rst_n),
        .i_sclk (i_sclk),
        .i_mosi (i_mosi),
        .i_cs   (i_cs),
        .o_miso (o_miso),
        .o_done (o_done),
        .o_err  (o_err)
    );

    always #5 i_clk_p = ~i_clk_p;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk_p);
    endtask

    task automatic check(input string name, input logic [F-1:0] act, input logic [F-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h required 0x%05h", name, act, req);
        end
    endtask

    task automatic push(input logic is_err, input logic [F-1:0] m);
        exp_t e;
        e.is_err = is_err;
        e.miso   = m;
        sb.push_back(e);
    endtask

    function automatic logic [F-1:0] top_mask(input int k);
        logic [F-1:0] m;
        m = '1;
        m = m << (F - k);
        return m;
    endfunction

    function automatic logic [F-1:0] mk_frame(input int a, input int b, input int op, input int pad);
        longint w;
        w = a;
        w = (w << N) | b;
        w = (w << M) | op;
        w = (w << (N + 4)) | pad;
        return w[F-1:0];
    endfunction

    // Reference: what the unit will return after executing (a, b, op)
    function automatic logic [F-1:0] model_exec(input int a, input int b, input int op);
        int     md, r, bf, fl;
        longint w;
        md = 1 << N;
        bf = 0;
        case (op)
            0: begin r = a + b; bf = (r >= md) ? 1 : 0; r = r % md; end
            1: begin r = (a - b + md) % md; bf = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = md - 1 - a;
            6: begin r = (a * 2) % md; bf = (a >= md / 2) ? 1 : 0; end
            7: begin r = a / 2; bf = a % 2; end
            default: r = 0;
        endcase
        fl = (((($countones(r) % 2) == 0) ? 1 : 0) << 3) | ((r == 0 ? 1 : 0) << 2)
             | (bf << 1) | (r >= md / 2 ? 1 : 0);
        w = a;
        w = (w << N) | b;
        w = (w << M) | op;
        w = (w << N) | r;
        w = (w << 4) | fl;
        return w[F-1:0];
    endfunction

    // Drive nbits of a mode-0 frame on chip-select cs, capturing MISO before each rise
    task automatic run_frame(input logic [F-1:0] frame, input int nbits,
                             input logic [CS_W-1:0] cs, input bit desel_last);
        last_cap = '0;
        nsel_bad = 1'b0;
        i_cs = cs;
        cyc(6);
        for (int k = 0; k < nbits; k++) begin
            i_mosi = frame[F-1-k];
            cyc(4);
            last_cap[F-1-k] = o_miso;
            nsel_bad = nsel_bad | o_miso;
            i_sclk = 1'b1;
            if (desel_last && (k == nbits - 1)) i_cs = '0;
            cyc(4);
            i_sclk = 1'b0;
        end
        cyc(4);
    endtask

    task automatic full_frame(input int a, input int b, input int op, input bit desel_last);
        push(1'b0, model_out);
        model_out = model_exec(a, b, op);
        run_frame(mk_frame(a, b, op, $urandom_range(0, 255)), F, CS_W'(SEL), desel_last);
        i_cs = '0;
        cyc(6);
    endtask

    // Monitor: every done/err pulse pops one expectation
    always @(negedge i_clk_p) begin
        exp_t e;
        if (i_rst_n && (o_done || o_err)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: done=%0b err=%0b, required no pulse", o_done, o_err);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({o_done, o_err} !== (e.is_err ? 2'b01 : 2'b10)) begin
                    n_bad++;
                    $display("FAIL event_kind: done=%0b err=%0b, required err=%0b",
                             o_done, o_err, e.is_err);
                end
                check("frame_miso", last_cap, e.miso);
            end
        end
    end

    initial begin
        logic [F-1:0] exp_v;
        int a, b, op, mode, k;

        // Reset state
        cyc(3);
        check("rst_miso", F'(o_miso), '0);
        check("rst_done", F'(o_done), '0);
        check("rst_err",  F'(o_err),  '0);
        i_rst_n = 1'b1;
        cyc(4);

        // Directed: first frame reads zeros, then 3+5, then 2-5
        push(1'b0, '0);
        run_frame(mk_frame(3, 5, 0, 0), F, CS_W'(SEL), 1'b0);
        i_cs = '0; cyc(6);
        exp_v = 20'h35081;
        push(1'b0, exp_v);
        run_frame(mk_frame(2, 5, 1, 0), F, CS_W'(SEL), 1'b0);
        i_cs = '0; cyc(6);

        // Deselect after 7 bits: abort, output preserved
        exp_v = 20'h251D3;
        push(1'b1, exp_v & top_mask(7));
        run_frame(mk_frame(15, 1, 0, 0), 7, CS_W'(SEL), 1'b0);
        i_cs = '0; cyc(6);
        push(1'b0, exp_v);
        model_out = model_exec(6, 9, 4);
        run_frame(mk_frame(6, 9, 4, 0), F, CS_W'(SEL), 1'b0);
        i_cs = '0; cyc(6);

        // Frame addressed elsewhere: no events, MISO held low
        run_frame(mk_frame(1, 1, 0, 0), F, CS_W'(2), 1'b0);
        check("nsel_miso", F'(nsel_bad), '0);
        i_cs = '0; cyc(6);

        // Timeout after 10 bits, then SCLK activity while still selected is ignored
        push(1'b1, model_out & top_mask(10));
        run_frame(mk_frame(7, 7, 0, 0), 10, CS_W'(SEL), 1'b0);
        cyc(TIMEOUT + 10);
        nsel_bad = 1'b0;
        for (int j = 0; j < 4; j++) begin
            i_sclk = 1'b1; cyc(4);
            nsel_bad = nsel_bad | o_miso;
            i_sclk = 1'b0; cyc(4);
            nsel_bad = nsel_bad | o_miso;
        end
        check("post_timeout_miso", F'(nsel_bad), '0);
        i_cs = '0; cyc(6);
        full_frame(9, 3, 1, 1'b0);

        // Deselect coincident with the last rise completes normally
        full_frame(12, 7, 0, 1'b1);

        // One-cycle reset mid-frame: no error, state cleared
        run_frame(mk_frame(5, 5, 2, 0), 8, CS_W'(SEL), 1'b0);
        i_rst_n = 1'b0;
        i_cs = '0;
        cyc(1);
        i_rst_n = 1'b1;
        cyc(6);
        model_out = '0;
        full_frame(10, 4, 3, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            a    = $urandom_range(0, 15);
            b    = $urandom_range(0, 15);
            op   = $urandom_range(0, 15);
            mode = $urandom_range(0, 7);
            if (mode <= 4) begin
                full_frame(a, b, op, 1'b0);
            end else if (mode == 5) begin
                full_frame(a, b, op, 1'b1);
            end else if (mode == 6) begin
                k = $urandom_range(1, F - 1);
                push(1'b1, model_out & top_mask(k));
                run_frame(mk_frame(a, b, op, 0), k, CS_W'(SEL), 1'b0);
                i_cs = '0; cyc(6);
            end else begin
                run_frame(mk_frame(a, b, op, 0), F, CS_W'((SEL + $urandom_range(1, 7)) % 8), 1'b0);
                check("rand_nsel_miso", F'(nsel_bad), '0);
                i_cs = '0; cyc(6);
            end
        end

        // Drain: every expected event must have appeared
        for (int w = 0; (w < 200) && (sb.size() != 0); w++) cyc(1);
        while (sb.size() != 0) begin
            void'(sb.pop_front());
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got none, required one more done/err pulse");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
